// File: rtl/spislave_le_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spislave_le_pkg
// Brief    : Shared SPI mode constants, idle fill default and FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package spislave_le_pkg;

    localparam int         c_CPOL      = 1;
    localparam int         c_CPHA      = 0;
    localparam logic [7:0] c_IDLE_FILL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spislave_le_sync_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spi_sync_edge
// Brief    : Multi-flop synchronizer for one SPI pin plus rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Reset to 1 so a pin already low at reset release reads as a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  =  r_sync[SYNC_STAGES-1] & ~r_hist;
    assign fall  = ~r_sync[SYNC_STAGES-1] &  r_hist;

endmodule
`default_nettype wire

// File: rtl/spislave_le.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spislave_le
// Brief    : Oversampled mode-2 SPI responder with byte TX holding register
//            and RX byte/word strobes (16-bit words, low byte first).
// Revision : 1.0 - initial release
// ============================================================================
module spislave_le
    import spislave_le_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_FILL   = c_IDLE_FILL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic [15:0] rx_word,
    output logic        rx_word_valid,
    output logic        active,
    output logic        tx_underrun,
    output logic        frame_err,
    input  logic        clr_status
);

    logic w_sck_lvl,  w_sck_rise,  w_sck_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_ss_lvl,   w_ss_rise,   w_ss_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .d(spi_sck),
        .level(w_sck_lvl), .rise(w_sck_rise), .fall(w_sck_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(spi_mosi),
        .level(w_mosi_lvl), .rise(w_mosi_rise), .fall(w_mosi_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .reset(reset), .d(spi_ss_n),
        .level(w_ss_lvl), .rise(w_ss_rise), .fall(w_ss_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_sck_lvl, w_mosi_rise, w_mosi_fall};

    state_t      r_state;
    logic [7:0]  r_txsh, r_rxsh, r_hold, r_rx_byte;
    logic [15:0] r_rx_word;
    logic [2:0]  r_bitcnt;
    logic        r_bytepar, r_tx_ready, r_miso, r_miso_oe, r_active;
    logic        r_byte_stb, r_word_stb, r_underrun, r_frame_err;

    logic       w_sample, w_shift, w_consume;
    logic [7:0] w_rx_next;

    // CPHA=0 samples on the leading edge, which is the fall when CPOL=1.
    assign w_sample  = ((c_CPOL != 0) != (c_CPHA != 0)) ? w_sck_fall : w_sck_rise;
    assign w_shift   = ((c_CPOL != 0) != (c_CPHA != 0)) ? w_sck_rise : w_sck_fall;
    assign w_rx_next = {r_rxsh[6:0], w_mosi_lvl};
    assign w_consume = (r_state == ST_LOAD) ||
                       ((r_state == ST_SHIFT) && !w_ss_rise && !w_sample &&
                        w_shift && (r_bitcnt == 3'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_txsh      <= 8'hFF;
            r_rxsh      <= 8'h00;
            r_hold      <= 8'h00;
            r_rx_byte   <= 8'h00;
            r_rx_word   <= 16'h0000;
            r_bitcnt    <= 3'd0;
            r_bytepar   <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_miso      <= 1'b1;
            r_miso_oe   <= 1'b0;
            r_active    <= 1'b0;
            r_byte_stb  <= 1'b0;
            r_word_stb  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_stb <= 1'b0;
            r_word_stb <= 1'b0;
            r_active   <= ~w_ss_lvl;
            r_miso_oe  <= ~w_ss_lvl;
            r_miso     <= r_txsh[7];

            if (clr_status) begin
                r_underrun  <= 1'b0;
                r_frame_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_bitcnt  <= 3'd0;
                    r_bytepar <= 1'b0;
                    r_state   <= w_ss_rise ? ST_IDLE : ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_ss_rise) begin
                        if (r_bitcnt != 3'd0) r_frame_err <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_sample) begin
                        r_rxsh   <= w_rx_next;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_rx_byte  <= w_rx_next;
                            r_byte_stb <= 1'b1;
                            if (r_bytepar) begin
                                r_rx_word[15:8] <= w_rx_next;
                                r_word_stb      <= 1'b1;
                            end else begin
                                r_rx_word[7:0]  <= w_rx_next;
                            end
                            r_bytepar <= ~r_bytepar;
                        end
                    end else if (w_shift && (r_bitcnt != 3'd0)) begin
                        r_txsh <= {r_txsh[6:0], 1'b0};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_consume) begin
                if (!r_tx_ready) begin
                    r_txsh     <= r_hold;
                    r_tx_ready <= 1'b1;
                end else begin
                    r_txsh     <= IDLE_FILL;
                    r_underrun <= 1'b1;
                end
            end

            // A write in the same cycle as a consume wins.
            if (tx_valid && r_tx_ready) begin
                r_hold     <= tx_data;
                r_tx_ready <= 1'b0;
            end
        end
    end

    assign spi_miso      = r_miso;
    assign spi_miso_oe   = r_miso_oe;
    assign tx_ready      = r_tx_ready;
    assign rx_byte       = r_rx_byte;
    assign rx_byte_valid = r_byte_stb;
    assign rx_word       = r_rx_word;
    assign rx_word_valid = r_word_stb;
    assign active        = r_active;
    assign tx_underrun   = r_underrun;
    assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spislave_le.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spislave_le
// Brief    : Table-driven SPI master bench for spislave_le plus corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spislave_le;

    logic        clk = 1'b0;
    logic        reset, spi_sck, spi_mosi, spi_ss_n, tx_valid, clr_status;
    logic [7:0]  tx_data;
    logic        spi_miso, spi_miso_oe, tx_ready, rx_byte_valid, rx_word_valid;
    logic        active, tx_underrun, frame_err;
    logic [7:0]  rx_byte;
    logic [15:0] rx_word;

    always #5 clk = ~clk;

    spislave_le #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_ss_n(spi_ss_n), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_word(rx_word),
        .rx_word_valid(rx_word_valid), .active(active),
        .tx_underrun(tx_underrun), .frame_err(frame_err), .clr_status(clr_status)
    );

    typedef struct {
        int          half;
        int          nbits;
        logic [23:0] mosi;
        logic        pre_v;
        logic [7:0]  pre;
        logic        mid_v;
        logic [7:0]  mid;
        logic [23:0] exp_miso;
        logic        exp_ufl;
    } vec_t;

    vec_t        vt[7];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  q_b[$];
    logic [15:0] q_w[$];
    logic [23:0] mi;
    int          base_b, base_w;

    always @(negedge clk) begin
        if (rx_byte_valid) q_b.push_back(rx_byte);
        if (rx_word_valid) q_w.push_back(rx_word);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_miso"},    32'(spi_miso), 32'd1);
        chk({tag, "_oe"},      32'(spi_miso_oe), 32'd0);
        chk({tag, "_txrdy"},   32'(tx_ready), 32'd1);
        chk({tag, "_rxbyte"},  32'(rx_byte), 32'd0);
        chk({tag, "_rxword"},  32'(rx_word), 32'd0);
        chk({tag, "_strobes"}, 32'({rx_byte_valid, rx_word_valid}), 32'd0);
        chk({tag, "_active"},  32'(active), 32'd0);
        chk({tag, "_flags"},   32'({tx_underrun, frame_err}), 32'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_status = 1'b1;
        @(negedge clk) clr_status = 1'b0;
    endtask

    task automatic offer(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        chk("offer_wait", 32'(n < 200), 32'd1);
        chk("tx_ready_after_offer", 32'(tx_ready), 32'd0);
    endtask

    // Mode-2 master; bytes go out low byte first, MSB first within a byte.
    // Unless keep_ss, SS_n rises while SCK is still low after the last bit.
    task automatic spi_frame(input int nbits, input logic [23:0] mo, input int half,
                             input bit keep_ss, output logic [23:0] mi_o);
        int idx;
        mi_o = '0;
        @(negedge clk) spi_ss_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            idx = (b / 8) * 8 + (7 - (b % 8));
            spi_mosi = mo[idx];
            repeat (half) @(negedge clk);
            mi_o[idx] = spi_miso;
            spi_sck   = 1'b0;
            repeat (half) @(negedge clk);
            if (b == nbits - 1 && !keep_ss) begin
                spi_ss_n = 1'b1;
                repeat (half) @(negedge clk);
            end
            spi_sck = 1'b1;
        end
        repeat (half) @(negedge clk);
    endtask

    initial begin
        vt[0] = '{5,  16, 24'h001234, 1'b0, 8'h00, 1'b0, 8'h00, 24'h00FFFF, 1'b1};
        vt[1] = '{5,  16, 24'h00BEEF, 1'b1, 8'hA5, 1'b1, 8'h5A, 24'h005AA5, 1'b0};
        vt[2] = '{5,   8, 24'h00003C, 1'b0, 8'h00, 1'b0, 8'h00, 24'h0000FF, 1'b1};
        vt[3] = '{6,  16, 24'h008001, 1'b1, 8'h96, 1'b1, 8'h0F, 24'h000F96, 1'b0};
        vt[4] = '{20, 16, 24'h007E42, 1'b1, 8'hC7, 1'b0, 8'h00, 24'h00FFC7, 1'b1};
        vt[5] = '{5,  24, 24'hD2B7E1, 1'b1, 8'h3B, 1'b1, 8'h81, 24'hFF813B, 1'b1};
        vt[6] = '{6,   8, 24'h0000C3, 1'b1, 8'h00, 1'b0, 8'h00, 24'h000000, 1'b0};

        reset = 1'b1; spi_sck = 1'b1; spi_mosi = 1'b0; spi_ss_n = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00; clr_status = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("rst0");
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            pulse_clr();
            base_b = q_b.size();
            base_w = q_w.size();
            if (vt[i].pre_v) offer(vt[i].pre);
            fork
                spi_frame(vt[i].nbits, vt[i].mosi, vt[i].half, 1'b0, mi);
                begin
                    if (vt[i].mid_v) begin
                        repeat (6 * vt[i].half) @(negedge clk);
                        chk("tx_ready_at_load", 32'(tx_ready), 32'd1);
                        offer(vt[i].mid);
                    end
                end
            join
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d_miso", i), 32'(mi), 32'(vt[i].exp_miso));
            chk($sformatf("v%0d_nbytes", i), 32'(q_b.size() - base_b), 32'(vt[i].nbits / 8));
            for (int k = 0; k < vt[i].nbits / 8; k++)
                chk($sformatf("v%0d_byte%0d", i, k),
                    (q_b.size() > base_b + k) ? 32'(q_b[base_b + k]) : 32'hxxxxxxxx,
                    32'(vt[i].mosi[8*k +: 8]));
            chk($sformatf("v%0d_nwords", i), 32'(q_w.size() - base_w), 32'(vt[i].nbits / 16));
            if (vt[i].nbits >= 16)
                chk($sformatf("v%0d_word", i),
                    (q_w.size() > base_w) ? 32'(q_w[base_w]) : 32'hxxxxxxxx,
                    32'(vt[i].mosi[15:0]));
            chk($sformatf("v%0d_underrun", i), 32'(tx_underrun), 32'(vt[i].exp_ufl));
            chk($sformatf("v%0d_frame_err", i), 32'(frame_err), 32'd0);
            chk($sformatf("v%0d_tx_ready", i), 32'(tx_ready), 32'd1);
            chk($sformatf("v%0d_idle", i), 32'({active, spi_miso_oe}), 32'd0);
        end

        // Partial byte: SS_n rises after 5 bits, next frame must realign.
        pulse_clr();
        base_b = q_b.size();
        base_w = q_w.size();
        spi_frame(5, 24'h0000A8, 5, 1'b0, mi);
        repeat (4) @(negedge clk);
        chk("part_nbytes", 32'(q_b.size() - base_b), 32'd0);
        chk("part_frame_err", 32'(frame_err), 32'd1);
        spi_frame(8, 24'h0000C3, 5, 1'b0, mi);
        repeat (4) @(negedge clk);
        chk("realign_nbytes", 32'(q_b.size() - base_b), 32'd1);
        chk("realign_byte", (q_b.size() > base_b) ? 32'(q_b[base_b]) : 32'hxxxxxxxx, 32'h0000_00C3);
        chk("realign_nwords", 32'(q_w.size() - base_w), 32'd0);
        chk("realign_err_sticky", 32'(frame_err), 32'd1);
        chk("realign_underrun", 32'(tx_underrun), 32'd1);
        pulse_clr();
        chk("clr_flags", 32'({tx_underrun, frame_err}), 32'd0);

        // Reset at bit 4 of byte 2 with a TX byte held.
        offer(8'h11);
        spi_frame(12, 24'h00F00F, 5, 1'b1, mi);
        chk("mid_active", 32'({active, spi_miso_oe}), 32'd3);
        offer(8'h22);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        spi_ss_n = 1'b1;
        check_reset_vals("rst1");
        repeat (10) @(negedge clk);
        pulse_clr();
        base_b = q_b.size();
        base_w = q_w.size();
        spi_frame(24, 24'h563412, 6, 1'b0, mi);
        repeat (4) @(negedge clk);
        chk("post_rst_nbytes", 32'(q_b.size() - base_b), 32'd3);
        chk("post_rst_nwords", 32'(q_w.size() - base_w), 32'd1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("post_rst_byte%0d", k),
                (q_b.size() > base_b + k) ? 32'(q_b[base_b + k]) : 32'hxxxxxxxx,
                32'(8'h12 + 8'(k * 8'h22)));
        chk("post_rst_word", (q_w.size() > base_w) ? 32'(q_w[base_w]) : 32'hxxxxxxxx, 32'h0000_3412);
        chk("post_rst_frame_err", 32'(frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
